// File: rtl/i2so_serializer.sv
// i2so_serializer
//
// Transmit-side I2S master serializer. Stereo words arrive with a one-cycle
// strobe and wait in a single-entry holding register until the next frame
// boundary. At that boundary they move into a 32-bit shift register that
// drives SD MSB first, with the left channel in slots 0..15 and the right
// channel in slots 16..31.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        run enable; low holds sck/ws/sd at 0 and parks the slot counter
//   in_data   stereo word, [31:16] left, [15:0] right
//   in_xfc    one-cycle strobe qualifying in_data
//   ready     holding register empty
//   sck       I2S bit clock (half period = CLK_DIV clk cycles)
//   ws        word select, 0 = left, 1 = right, leads each MSB by one slot
//   sd        serial data, updated on sck falling edges only
//   underrun  one-cycle pulse when a frame starts with no word available
//   overrun   one-cycle pulse when a strobed word is dropped
module i2so_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] in_data,
  input  logic        in_xfc,
  output logic        ready,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic [31:0] holding;
  logic        full;

  logic        tick;
  logic        fall;
  logic        load;
  logic [4:0]  bit_nxt;
  logic [31:0] shift_nxt;

  // WS goes high one slot ahead of the right MSB and drops one slot ahead
  // of the next left MSB.
  function automatic logic ws_for_slot(input logic [4:0] slot);
    return (slot >= 5'd15) && (slot <= 5'd30);
  endfunction

  always_comb begin
    tick    = en && (div_cnt == DIV_LAST);
    fall    = tick && sck;
    bit_nxt = bit_cnt + 5'd1;
    load    = fall && (bit_cnt == 5'd31);
    if (load) begin
      // A word strobed in the load cycle with holding empty bypasses straight
      // into the shift register.
      if (full)        shift_nxt = holding;
      else if (in_xfc) shift_nxt = in_data;
      else             shift_nxt = '0;
    end else begin
      shift_nxt = {shift_reg[30:0], 1'b0};
    end
  end

  assign ready = ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= 5'd31;
      shift_reg <= '0;
      holding   <= '0;
      full      <= 1'b0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;

      // Bit clock and slot timing; disabled means parked just before slot 0.
      if (!en) begin
        div_cnt <= '0;
        sck     <= 1'b0;
        ws      <= 1'b0;
        sd      <= 1'b0;
        bit_cnt <= 5'd31;
      end else begin
        if (tick) begin
          div_cnt <= '0;
          sck     <= ~sck;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (fall) begin
          bit_cnt   <= bit_nxt;
          shift_reg <= shift_nxt;
          sd        <= shift_nxt[31];
          ws        <= ws_for_slot(bit_nxt);
          if (load && !full && !in_xfc) underrun <= 1'b1;
        end
      end

      // Holding register; keeps accepting words while disabled.
      if (in_xfc) begin
        if (!full) begin
          if (!load) begin
            holding <= in_data;
            full    <= 1'b1;
          end
        end else if (load) begin
          holding <= in_data;
        end else begin
          overrun <= 1'b1;
        end
      end else if (load) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2so_serializer.sv
// tb_i2so_serializer
//
// Directed bench for i2so_serializer with CLK_DIV=2. The stimulus process
// pushes the expected content of each frame, together with its expected
// underrun flag, into a queue. A monitor reassembles SD on every observed
// SCK falling edge. It checks WS per slot, the SCK period and the underrun
// pulse, and pops and compares the queue at every frame.
module tb_i2so_serializer;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] in_data;
  logic        in_xfc;
  logic        ready;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        underrun;
  logic        overrun;

  i2so_serializer #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_data  (in_data),
    .in_xfc   (in_xfc),
    .ready    (ready),
    .sck      (sck),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic        under;
  } sb_t;

  sb_t q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic u);
    q.push_back(sb_t'{w, u});
  endtask

  function automatic logic ws_exp(input logic [4:0] s);
    return (s >= 5'd15) && (s <= 5'd30);
  endfunction

  // Monitor
  logic       en_s;
  logic       sck_prev = 1'b0;
  logic [4:0] m_slot = 5'd31;
  logic       m_fell = 1'b0;
  int         m_gap = 0;
  logic [31:0] m_word = '0;
  sb_t        m_cur = '0;

  always @(posedge clk) en_s <= en;

  always @(negedge clk) begin
    sck_prev <= sck;
    if (!rst_n) begin
      m_slot <= 5'd31;
      m_gap  <= 0;
      m_fell <= 1'b0;
    end else begin
      m_fell <= 1'b0;
      if (en_s && sck_prev && !sck) begin
        m_fell <= 1'b1;
        m_slot <= m_slot + 5'd1;
        m_gap  <= 0;
        chk("sck_period", 32'(m_gap + 1), 32'(2 * CLK_DIV));
        chk("ws_slot", {31'd0, ws}, {31'd0, ws_exp(m_slot + 5'd1)});
        m_word <= {m_word[30:0], sd};
        if (m_slot == 5'd31) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty: observed frame start, expected no frame");
          end else begin
            chk("underrun_slot0", {31'd0, underrun}, {31'd0, q[0].under});
            m_cur <= q.pop_front();
          end
        end else begin
          chk("underrun_idle", {31'd0, underrun}, 32'd0);
        end
        if (m_slot == 5'd30) chk("frame_word", {m_word[30:0], sd}, m_cur.word);
      end else begin
        if (en_s) begin
          m_gap <= m_gap + 1;
        end else begin
          m_gap  <= 0;
          m_slot <= 5'd31;
        end
        chk("underrun_idle", {31'd0, underrun}, 32'd0);
      end
    end
  end

  task automatic wait_slot(input logic [4:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(m_fell && m_slot == s) && n < 2000);
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_slot_timeout: observed no slot %0d, expected one", s);
    end
  endtask

  task automatic strobe(input logic [31:0] w);
    @(posedge clk); #1;
    in_data = w;
    in_xfc  = 1'b1;
    @(posedge clk); #1;
    in_xfc  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_xfc = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_ws", {31'd0, ws}, 32'd0);
    chk("rst_sd", {31'd0, sd}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;

    // Single word accepted while disabled, then an underrun frame.
    strobe(32'hA5A5_3C3C);
    chk("ready_fall", {31'd0, ready}, 32'd0);
    push(32'hA5A5_3C3C, 1'b0);
    push(32'h0000_0000, 1'b1);
    en = 1'b1;
    wait_slot(5'd0);
    chk("ready_after_load", {31'd0, ready}, 32'd1);

    // Overrun during the underrun frame.
    wait_slot(5'd0);
    wait_slot(5'd5);
    @(posedge clk); #1;
    in_data = 32'h1111_2222; in_xfc = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h3333_4444;
    chk("ready_held", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    in_xfc = 1'b0;
    chk("overrun_pulse", {31'd0, overrun}, 32'd1);
    push(32'h1111_2222, 1'b0);
    @(posedge clk); #1;
    chk("overrun_clear", {31'd0, overrun}, 32'd0);

    // Strobe coinciding with the frame load while holding is empty.
    wait_slot(5'd0);
    wait_slot(5'd31);
    push(32'hFFFF_0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    in_data = 32'hFFFF_0000; in_xfc = 1'b1;
    @(posedge clk); #1;
    in_xfc = 1'b0;
    chk("bypass_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("bypass_ready2", {31'd0, ready}, 32'd1);

    // Enable drop mid-frame, word accepted while disabled, then re-enable.
    wait_slot(5'd2);
    strobe(32'hC3C3_5A5A);
    push(32'hC3C3_5A5A, 1'b0);
    wait_slot(5'd0);
    wait_slot(5'd20);
    repeat (2) @(posedge clk);
    #1;
    chk("sck_before_drop", {31'd0, sck}, 32'd1);
    chk("ws_before_drop", {31'd0, ws}, 32'd1);
    chk("sd_before_drop", {31'd0, sd}, 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_sck", {31'd0, sck}, 32'd0);
    chk("dis_ws", {31'd0, ws}, 32'd0);
    chk("dis_sd", {31'd0, sd}, 32'd0);
    strobe(32'h0F0F_F0F0);
    chk("dis_accept", {31'd0, ready}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("dis_hold_sck", {31'd0, sck}, 32'd0);
    chk("dis_hold_ws", {31'd0, ws}, 32'd0);
    chk("dis_hold_sd", {31'd0, sd}, 32'd0);
    chk("dis_hold_ready", {31'd0, ready}, 32'd0);
    push(32'h0F0F_F0F0, 1'b0);
    en = 1'b1;
    wait_slot(5'd0);
    wait_slot(5'd31);

    // Asynchronous reset mid-frame with a word in holding.
    push(32'h0000_0000, 1'b1);
    wait_slot(5'd18);
    strobe(32'h1234_5678);
    chk("pre_rst_ready", {31'd0, ready}, 32'd0);
    wait_slot(5'd20);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sck", {31'd0, sck}, 32'd0);
    chk("arst_ws", {31'd0, ws}, 32'd0);
    chk("arst_sd", {31'd0, sd}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_underrun", {31'd0, underrun}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
